// File: rtl/pfd_lock_detector.sv
// Counter-based phase/frequency detector: measures signed rising-edge separation of
// two asynchronous clocks in fpga_clk_i cycles, flags cycle slips and reports lock.
`timescale 1ns/1ps
module pfd_lock_detector #(
  parameter int ERR_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_TOL    = 2,
  parameter int LOCK_CNT    = 4
) (
  input  logic                    fpga_clk_i,
  input  logic                    reset_i,
  input  logic                    enable_i,
  input  logic                    ref_clk_i,
  input  logic                    gen_clk_i,
  output logic signed [ERR_W-1:0] error_o,
  output logic                    error_valid_o,
  output logic                    lock_o,
  output logic                    slip_o
);

  localparam int               CNT_W     = ERR_W - 1;
  localparam int               LCW       = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] ERR_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TOL       = CNT_W'(LOCK_TOL);
  localparam logic [LCW-1:0]   LOCK_FULL = LCW'(LOCK_CNT);

  typedef enum logic [1:0] {IDLE, REF_LEAD, GEN_LEAD} state_e;

  logic [SYNC_STAGES-1:0] ref_sync_q, ref_sync_d, gen_sync_q, gen_sync_d;
  logic                   ref_hist_q, ref_hist_d, gen_hist_q, gen_hist_d;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [LCW-1:0]         lock_cnt_q, lock_cnt_d;
  logic signed [ERR_W-1:0] error_q, error_d, mag_s;
  logic                   valid_q, valid_d, slip_q, slip_d, lock_q, lock_d;
  logic                   ref_rise, gen_rise;
  logic                   meas_valid, meas_slip, meas_neg;
  logic [CNT_W-1:0]       meas_mag;

  // Both inputs see the same synchroniser depth, so their relative timing is preserved.
  always_comb begin
    ref_sync_d = {ref_sync_q[SYNC_STAGES-2:0], ref_clk_i};
    gen_sync_d = {gen_sync_q[SYNC_STAGES-2:0], gen_clk_i};
    ref_hist_d = ref_sync_q[SYNC_STAGES-1];
    gen_hist_d = gen_sync_q[SYNC_STAGES-1];
    ref_rise   = ref_sync_q[SYNC_STAGES-1] & ~ref_hist_q;
    gen_rise   = gen_sync_q[SYNC_STAGES-1] & ~gen_hist_q;
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cnt_inc    = (cnt_q == ERR_MAX) ? cnt_q : cnt_q + CNT_ONE;
    meas_valid = 1'b0;
    meas_slip  = 1'b0;
    meas_neg   = 1'b0;
    meas_mag   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (ref_rise && gen_rise) begin
          meas_valid = 1'b1;
          meas_mag   = '0;
        end else if (ref_rise) begin
          state_d = REF_LEAD;
          cnt_d   = CNT_ONE;
        end else if (gen_rise) begin
          state_d = GEN_LEAD;
          cnt_d   = CNT_ONE;
        end
      end
      REF_LEAD: begin
        if (gen_rise) begin
          meas_valid = 1'b1;
          if (ref_rise) cnt_d = CNT_ONE;
          else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else if (ref_rise) begin
          meas_valid = 1'b1;
          meas_slip  = 1'b1;
          meas_mag   = ERR_MAX;
          cnt_d      = CNT_ONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      GEN_LEAD: begin
        meas_neg = 1'b1;
        if (ref_rise) begin
          meas_valid = 1'b1;
          if (gen_rise) cnt_d = CNT_ONE;
          else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else if (gen_rise) begin
          meas_valid = 1'b1;
          meas_slip  = 1'b1;
          meas_mag   = ERR_MAX;
          cnt_d      = CNT_ONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (!enable_i) begin
      state_d    = IDLE;
      cnt_d      = '0;
      meas_valid = 1'b0;
      meas_slip  = 1'b0;
    end
  end

  // Lock qualification: an out-of-tolerance result drops lock with its own strobe.
  always_comb begin
    mag_s      = $signed({1'b0, meas_mag});
    error_d    = error_q;
    valid_d    = meas_valid;
    slip_d     = meas_slip;
    lock_cnt_d = lock_cnt_q;
    lock_d     = (lock_cnt_q == LOCK_FULL);
    if (meas_valid) begin
      error_d = meas_neg ? -mag_s : mag_s;
      if (meas_mag <= TOL) begin
        if (lock_cnt_q != LOCK_FULL) lock_cnt_d = lock_cnt_q + LCW'(1);
      end else begin
        lock_cnt_d = '0;
        lock_d     = 1'b0;
      end
    end
    if (!enable_i) begin
      lock_cnt_d = '0;
      lock_d     = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      ref_sync_q <= '0;
      gen_sync_q <= '0;
      ref_hist_q <= 1'b0;
      gen_hist_q <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      lock_cnt_q <= '0;
      error_q    <= '0;
      valid_q    <= 1'b0;
      slip_q     <= 1'b0;
      lock_q     <= 1'b0;
    end else begin
      ref_sync_q <= ref_sync_d;
      gen_sync_q <= gen_sync_d;
      ref_hist_q <= ref_hist_d;
      gen_hist_q <= gen_hist_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lock_cnt_q <= lock_cnt_d;
      error_q    <= error_d;
      valid_q    <= valid_d;
      slip_q     <= slip_d;
      lock_q     <= lock_d;
    end
  end

  assign error_o       = error_q;
  assign error_valid_o = valid_q;
  assign slip_o        = slip_q;
  assign lock_o        = lock_q;

endmodule

// File: tb/tb_pfd_lock_detector.sv
// Self-checking bench for pfd_lock_detector: table-driven edge-pair windows with a
// scoreboard of expected strobes, plus hand-written enable, slip and reset sequences.
`timescale 1ns/1ps
module tb_pfd_lock_detector;

  localparam int ERR_MAX  = 127;
  localparam int LOCK_TOL = 2;
  localparam int LOCK_CNT = 4;

  typedef struct {
    int err;
    bit slip;
  } exp_t;

  typedef struct {
    int lag;      // gen edge relative to ref edge, ns (+ve = gen lags)
    bit gen_on;
    int n;        // windows in this row
    int exp_err;
    bit exp_lock; // lock_o at end of row
  } row_t;

  logic              clk = 1'b0;
  logic              reset_i, enable_i, ref_clk_i, gen_clk_i;
  logic signed [7:0] error_o;
  logic              error_valid_o, lock_o, slip_o;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   run      = 0;
  int   last_err = 0;
  bit   pend_ref = 0;
  bit   pend_gen = 0;

  pfd_lock_detector dut (
    .fpga_clk_i    (clk),
    .reset_i       (reset_i),
    .enable_i      (enable_i),
    .ref_clk_i     (ref_clk_i),
    .gen_clk_i     (gen_clk_i),
    .error_o       (error_o),
    .error_valid_o (error_valid_o),
    .lock_o        (lock_o),
    .slip_o        (slip_o)
  );

  always #2 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One ~200ns window starting 1ns after a clock edge: one ref pulse, optional gen pulse.
  task automatic drive_window(input int lag, input bit gen_on, input int exp_err);
    int t_ref, t_gen, t_last;
    t_ref  = (lag >= 0) ? 0 : -lag;
    t_gen  = (lag >= 0) ? lag : 0;
    t_last = (gen_on && t_gen > t_ref) ? t_gen : t_ref;
    @(posedge clk);
    #1;
    if (enable_i) begin
      if (!gen_on) begin
        if (pend_ref) sb.push_back('{ERR_MAX, 1'b1});
        pend_ref = 1'b1;
      end else if (lag > 0) begin
        if (pend_ref) sb.push_back('{ERR_MAX, 1'b1});
        sb.push_back('{exp_err, 1'b0});
        pend_ref = 1'b0;
      end else if (lag < 0) begin
        if (pend_gen) sb.push_back('{-ERR_MAX, 1'b1});
        sb.push_back('{exp_err, 1'b0});
        pend_gen = 1'b0;
      end else begin
        sb.push_back('{exp_err, 1'b0});
      end
    end
    fork
      begin #(t_ref); ref_clk_i = 1'b1; #50; ref_clk_i = 1'b0; end
      begin if (gen_on) begin #(t_gen); gen_clk_i = 1'b1; #50; gen_clk_i = 1'b0; end end
    join
    #(148 - t_last);
  endtask

  // Strobe monitor: compares each strobe against the scoreboard and a lock-run model.
  initial begin
    exp_t e;
    bit   in_tol;
    forever begin
      @(negedge clk);
      if (error_valid_o) begin
        if (sb.size() == 0) begin
          check("unexpected_strobe", int'(error_o), 0);
        end else begin
          e      = sb.pop_front();
          in_tol = (e.err <= LOCK_TOL) && (e.err >= -LOCK_TOL);
          check("strobe_error", int'(error_o), e.err);
          check("strobe_slip", int'(slip_o), int'(e.slip));
          check("strobe_lock", int'(lock_o), (in_tol && run >= LOCK_CNT) ? 1 : 0);
          run      = in_tol ? ((run < LOCK_CNT) ? run + 1 : run) : 0;
          last_err = e.err;
          @(negedge clk);
          check("lock_after_strobe", int'(lock_o), (run >= LOCK_CNT) ? 1 : 0);
        end
      end
    end
  end

  initial begin
    row_t rows[9];
    rows[0] = '{ 20, 1'b1, 3,  5, 1'b0};
    rows[1] = '{-12, 1'b1, 3, -3, 1'b0};
    rows[2] = '{  4, 1'b1, 5,  1, 1'b1};
    rows[3] = '{ 40, 1'b1, 2, 10, 1'b0};
    rows[4] = '{  0, 1'b1, 2,  0, 1'b0};
    rows[5] = '{  0, 1'b0, 3,  0, 1'b0};
    rows[6] = '{ 20, 1'b1, 2,  5, 1'b0};
    rows[7] = '{ 12, 1'b1, 1,  3, 1'b0};
    rows[8] = '{ -8, 1'b1, 5, -2, 1'b1};

    reset_i   = 1'b1;
    enable_i  = 1'b1;
    ref_clk_i = 1'b0;
    gen_clk_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_error", int'(error_o), 0);
    check("reset_valid", int'(error_valid_o), 0);
    check("reset_lock", int'(lock_o), 0);
    check("reset_slip", int'(slip_o), 0);
    reset_i = 1'b0;

    for (int r = 0; r < 9; r++) begin
      for (int k = 0; k < rows[r].n; k++)
        drive_window(rows[r].lag, rows[r].gen_on, rows[r].exp_err);
      check($sformatf("row%0d_lock", r), int'(lock_o), int'(rows[r].exp_lock));
    end

    // Disable in the middle of a REF_LEAD measurement, hold off for three ref periods.
    @(posedge clk);
    #1;
    ref_clk_i = 1'b1;
    #16;
    enable_i = 1'b0;
    run      = 0;
    pend_ref = 1'b0;
    pend_gen = 1'b0;
    #4;
    gen_clk_i = 1'b1;
    #30;
    ref_clk_i = 1'b0;
    #20;
    gen_clk_i = 1'b0;
    #100;
    check("disable_lock", int'(lock_o), 0);
    check("disable_error_hold", int'(error_o), last_err);
    drive_window(20, 1'b1, 5);
    drive_window(20, 1'b1, 5);
    check("disabled_lock", int'(lock_o), 0);
    check("disabled_error_hold", int'(error_o), last_err);
    enable_i = 1'b1;
    drive_window(20, 1'b1, 5);
    drive_window(20, 1'b1, 5);

    for (int k = 0; k < 5; k++) drive_window(4, 1'b1, 1);
    check("relock", int'(lock_o), 1);

    // Reset pulse while REF_LEAD is counting: measurement dropped, outputs cleared.
    @(posedge clk);
    #1;
    ref_clk_i = 1'b1;
    #50;
    ref_clk_i = 1'b0;
    #30;
    reset_i = 1'b1;
    @(posedge clk);
    #1;
    reset_i  = 1'b0;
    run      = 0;
    pend_ref = 1'b0;
    pend_gen = 1'b0;
    check("midreset_error", int'(error_o), 0);
    check("midreset_valid", int'(error_valid_o), 0);
    check("midreset_lock", int'(lock_o), 0);
    check("midreset_slip", int'(slip_o), 0);
    #100;
    drive_window(20, 1'b1, 5);

    repeat (20) @(posedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
